// File: rtl/seqdet_pkg.sv
// Shared constants, lane configuration type and width helpers for seqdet_multi.
// Optional hit counters are built only when SEQDET_COUNT_EN is defined.
package seqdet_pkg;

    localparam int PAT_MAX = 16;
    localparam int LEN_MAX = 5;

    localparam logic [2:0] PAT0_DEF = 3'b101;
    localparam logic [2:0] PAT1_DEF = 3'b110;
    localparam int         LEN_DEF  = 3;

    typedef struct packed {
        logic [PAT_MAX-1:0] pat;
        logic [LEN_MAX-1:0] len;
    } lane_cfg_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int len_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Power-up lane contents: the legacy 101/110 detector on lanes 0 and 1.
    function automatic lane_cfg_t def_cfg(input int lane, input int w);
        lane_cfg_t c;
        c.pat = '0;
        c.len = '0;
        if (lane < 2) begin
            c.pat = PAT_MAX'((lane == 0) ? PAT0_DEF : PAT1_DEF);
            c.len = LEN_MAX'((w < LEN_DEF) ? w : LEN_DEF);
        end
        return c;
    endfunction

endpackage

// File: rtl/seqdet_lane.sv
// One detector lane: pattern/length registers, fill counter, Mealy compare
// against the shared window, and the optional SEQDET_COUNT_EN hit counter.
module seqdet_lane
    import seqdet_pkg::*;
#(
    parameter int W    = 8,
    parameter int CW   = 8,
    parameter int LANE = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [W-1:0]       win,
    input  logic               overlap,
    input  logic               cfg_we,
    input  logic [W-1:0]       cfg_pat,
    input  logic [LEN_MAX-1:0] cfg_len,
`ifdef SEQDET_COUNT_EN
    input  logic               cnt_clr,
    output logic [CW-1:0]      cnt,
`endif
    output logic               hit
);

    lane_cfg_t          cfg_q, cfg_d;
    logic [LEN_MAX-1:0] fill_q, fill_d;
    logic [PAT_MAX-1:0] mask;
    logic [PAT_MAX-1:0] win_ext;

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int k = 0; k < PAT_MAX; k++) begin
            mask[k] = (k < int'(cfg_q.len));
        end
        win_ext = PAT_MAX'(win);
        hit = d_valid && (cfg_q.len != '0)
              && (int'(fill_q) + 1 >= int'(cfg_q.len))
              && (((win_ext ^ cfg_q.pat) & mask) == '0);
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cfg_d  = cfg_q;
        fill_d = fill_q;
        if (cfg_we) begin
            cfg_d.pat = PAT_MAX'(cfg_pat);
            cfg_d.len = cfg_len;
            fill_d    = '0;
        end else if (d_valid) begin
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (int'(fill_q) < W - 1) begin
                fill_d = fill_q + LEN_MAX'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cfg_q  <= def_cfg(LANE, W);
            fill_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/seqdet_multi.sv
// Multi-pattern Mealy serial sequence detector: shared history, cfg decode,
// NPAT lanes and the z reduction. SEQDET_COUNT_EN adds per-lane hit counters.
module seqdet_multi
    import seqdet_pkg::*;
#(
    parameter int W    = 8,
    parameter int NPAT = 2,
    parameter int CW   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   d,
    input  logic                   d_valid,
    input  logic [NPAT-1:0]        overlap,
    input  logic                   cfg_we,
    input  logic [idx_w(NPAT)-1:0] cfg_idx,
    input  logic [W-1:0]           cfg_pat,
    input  logic [len_w(W)-1:0]    cfg_len,
`ifdef SEQDET_COUNT_EN
    input  logic                   cnt_clr,
    output logic [NPAT*CW-1:0]     hit_cnt,
`endif
    output logic [NPAT-1:0]        hit,
    output logic                   z
);

    localparam int IW = idx_w(NPAT);
    localparam int LW = len_w(W);

    logic [W-2:0] hist_q, hist_d;
    logic [W-1:0] win;
    logic [LW-1:0] len_cl;

    // The window seen by every lane is the history plus the bit arriving now.
    assign win = {hist_q, d};

    always_comb begin
        hist_d = hist_q;
        if (d_valid) begin
            hist_d = win[W-2:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign len_cl = (cfg_len > LW'(W)) ? LW'(W) : cfg_len;

    // Lane indices at or above NPAT match no lane, so such writes are dropped.
    for (genvar i = 0; i < NPAT; i++) begin : g_lane
        seqdet_lane #(
            .W   (W),
            .CW  (CW),
            .LANE(i)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .d_valid(d_valid),
            .win    (win),
            .overlap(overlap[i]),
            .cfg_we (cfg_we && (cfg_idx == IW'(i))),
            .cfg_pat(cfg_pat),
            .cfg_len(LEN_MAX'(len_cl)),
`ifdef SEQDET_COUNT_EN
            .cnt_clr(cnt_clr),
            .cnt    (hit_cnt[i*CW +: CW]),
`endif
            .hit    (hit[i])
        );
    end

    assign z = |hit;

endmodule

// File: tb/tb_seqdet_multi.sv
// Self-checking bench for seqdet_multi: directed scenarios plus random traffic
// compared every cycle against a stream-based reference model.
module tb_seqdet_multi;

    localparam int W    = 8;
    localparam int NPAT = 2;
    localparam int CW   = 2;
    localparam int IW   = 1;
    localparam int CMAX = (1 << CW) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              d, d_valid;
    logic [NPAT-1:0]   overlap;
    logic              cfg_we;
    logic [IW-1:0]     cfg_idx;
    logic [W-1:0]      cfg_pat;
    logic [3:0]        cfg_len;
    logic              cnt_clr;
    logic [NPAT*CW-1:0] hit_cnt;
    logic [NPAT-1:0]   hit;
    logic              z;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw accepted bits plus bits-since-clear per lane.
    bit          stream[$];
    logic [W-1:0] m_pat[NPAT];
    int          m_len[NPAT];
    int          m_cnt[NPAT];
    int          m_ctr[NPAT];
    bit [NPAT-1:0] exp_hit;
    logic [NPAT-1:0] last_hit;
    logic        last_z;

    seqdet_multi #(.W(W), .NPAT(NPAT), .CW(CW)) dut (
        .clock  (clock),
        .reset  (reset),
        .d      (d),
        .d_valid(d_valid),
        .overlap(overlap),
        .cfg_we (cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_pat(cfg_pat),
        .cfg_len(cfg_len),
`ifdef SEQDET_COUNT_EN
        .cnt_clr(cnt_clr),
        .hit_cnt(hit_cnt),
`endif
        .hit    (hit),
        .z      (z)
    );

`ifndef SEQDET_COUNT_EN
    assign hit_cnt = '0;
`endif

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        stream.delete();
        for (int i = 0; i < NPAT; i++) begin
            m_pat[i] = '0;
            m_len[i] = 0;
            m_cnt[i] = 0;
            m_ctr[i] = 0;
        end
        m_pat[0] = 8'b101;
        m_len[0] = 3;
        if (NPAT > 1) begin
            m_pat[1] = 8'b110;
            m_len[1] = 3;
        end
    endtask

    task automatic model_compare();
        bit e, b;
        for (int i = 0; i < NPAT; i++) begin
            e = 1'b0;
            if (d_valid && m_len[i] > 0 && m_cnt[i] >= m_len[i] - 1) begin
                e = 1'b1;
                for (int k = 0; k < m_len[i]; k++) begin
                    b = (k == 0) ? d : stream[stream.size() - k];
                    if (b != m_pat[i][k]) e = 1'b0;
                end
            end
            exp_hit[i] = e;
            check($sformatf("hit%0d", i), 32'(hit[i]), 32'(e));
`ifdef SEQDET_COUNT_EN
            check($sformatf("cnt%0d", i), 32'(hit_cnt[i*CW +: CW]), m_ctr[i]);
`endif
        end
        check("z", 32'(z), 32'(|exp_hit));
    endtask

    task automatic model_update();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NPAT; i++) begin
            if (cfg_we && int'(cfg_idx) == i) begin
                m_pat[i] = cfg_pat;
                m_len[i] = (int'(cfg_len) > W) ? W : int'(cfg_len);
                m_cnt[i] = 0;
            end else if (d_valid) begin
                if (exp_hit[i] && !overlap[i]) m_cnt[i] = 0;
                else m_cnt[i]++;
            end
            if (cnt_clr) m_ctr[i] = 0;
            else if (exp_hit[i] && m_ctr[i] < CMAX) m_ctr[i]++;
        end
        if (d_valid) begin
            stream.push_back(d);
            if (stream.size() > 40) void'(stream.pop_front());
        end
    endtask

    // One clock: apply inputs, compare mid-cycle, advance the model at the edge.
    task automatic drive(input logic b, input logic v);
        d       = b;
        d_valid = v;
        #4;
        model_compare();
        last_hit = hit;
        last_z   = z;
        @(posedge clock);
        model_update();
        #1;
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0);
        reset = 1'b1;
    endtask

    logic [5:0] v0, v1, vz;
    logic [4:0] w0;
    logic [7:0] byte_v;
    int nhit;

    initial begin
        reset = 1'b0; d = 1'b0; d_valid = 1'b0; overlap = '1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_len = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_z", 32'(z), 32'd0);
`ifdef SEQDET_COUNT_EN
        check("rst_cnt", 32'(hit_cnt), 32'd0);
`endif
        reset = 1'b1;

        // Default patterns, both lanes overlapping.
        do_reset();
        overlap = 2'b11;
        byte_v = 8'b0011_0110;
        for (int k = 0; k < 6; k++) begin
            drive(byte_v[5-k], 1'b1);
            v0[k] = last_hit[0];
            v1[k] = last_hit[1];
            vz[k] = last_z;
        end
        check("dflt_l0", 32'(v0), 32'b001000);
        check("dflt_l1", 32'(v1), 32'b100100);
        check("dflt_z", 32'(vz), 32'b101100);

        // 10101 on lane 0, non-overlapping then overlapping.
        for (int m = 0; m < 2; m++) begin
            do_reset();
            overlap = (m == 0) ? 2'b10 : 2'b11;
            for (int k = 0; k < 5; k++) begin
                drive(k % 2 == 0, 1'b1);
                w0[k] = last_hit[0];
            end
            check(m == 0 ? "nonovl_l0" : "ovl_l0", 32'(w0), (m == 0) ? 32'b00100 : 32'b10100);
        end

        // Full-width pattern streamed MSB-first with valid gaps.
        do_reset();
        overlap = 2'b11;
        byte_v = 8'b1011_0010;
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_pat = byte_v; cfg_len = 4'd8;
        drive(1'b0, 1'b0);
        nhit = 0;
        for (int k = 7; k >= 0; k--) begin
            drive(byte_v[k], 1'b1);
            if (last_hit[0]) nhit++;
            if (k == 0) check("byte_last", 32'(last_hit[0]), 32'd1);
            for (int g = 0; g < (k % 3); g++) begin
                drive(1'($urandom), 1'b0);
                check("gap_z", 32'(last_z), 32'd0);
            end
        end
        check("byte_nhit", nhit, 1);

        // Reset mid-stream discards the partial 10.
        do_reset();
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        do_reset();
        drive(1'b1, 1'b1);
        check("post_rst_nohit", 32'(last_z), 32'd0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        check("post_rst_hit", 32'(last_hit[0]), 32'd1);

        // Write lane 1 in the cycle its 110 completes.
        do_reset();
        overlap = 2'b11;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        cfg_we = 1'b1; cfg_idx = 1'b1; cfg_pat = 8'b01; cfg_len = 4'd2;
        drive(1'b0, 1'b1);
        check("we_old_hit", 32'(last_hit[1]), 32'd1);
        drive(1'b1, 1'b1);
        check("we_fill_clr", 32'(last_hit[1]), 32'd0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        check("we_new_hit", 32'(last_hit[1]), 32'd1);

`ifdef SEQDET_COUNT_EN
        // Five lane-0 hits saturate a 2-bit counter; clear beats a hit.
        do_reset();
        overlap = 2'b11;
        drive(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
        end
        check("cnt_sat", 32'(hit_cnt[CW-1:0]), 32'd3);
        drive(1'b0, 1'b1);
        cnt_clr = 1'b1;
        drive(1'b1, 1'b1);
        check("clr_hit", 32'(last_hit[0]), 32'd1);
        check("clr_cnt", 32'(hit_cnt[CW-1:0]), 32'd0);
`endif

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) overlap = 2'($urandom);
            if ($urandom_range(0, 99) < 4) begin
                cfg_we  = 1'b1;
                cfg_idx = 1'($urandom_range(0, NPAT - 1));
                cfg_pat = 8'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4));
            end
            cnt_clr = ($urandom_range(0, 99) < 2);
            reset   = ($urandom_range(0, 199) != 0);
            drive(1'($urandom), $urandom_range(0, 3) != 0);
            reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
